// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational 32-bit ALU: accepts one request, holds operands
// for SETTLE_CYC cycles, captures the result and returns it over a valid/ready handshake.
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_op,
  input  logic [31:0]      alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_illegal,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SetW-1:0] SettleInit = SetW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [SetW-1:0]   r_cnt;
  logic [31:0]       r_alu_a;
  logic [31:0]       r_alu_b;
  logic [4:0]        r_alu_op;
  logic [31:0]       r_rsp_data;
  logic              r_rsp_illegal;
  logic [CNT_W-1:0]  r_done_count;

  logic              w_accept;
  logic              w_capture;
  logic              w_rsp_hs;

  assign w_accept  = req_valid && (r_state == StIdle);
  assign w_capture = (r_state == StSettle) && (r_cnt == '0);
  assign w_rsp_hs  = rsp_ready && (r_state == StResp);

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_accept)  w_state_d = StSettle;
      StSettle: if (w_capture) w_state_d = StResp;
      StResp:   if (w_rsp_hs)  w_state_d = StIdle;
      default:                 w_state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      StSettle: ;
      StResp:   rsp_valid = 1'b1;
      default: begin
        req_ready = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

  // Settle counter: loaded on acceptance, counts down to zero before capture
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= SettleInit;
    end else if ((r_state == StSettle) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - SetW'(1);
    end
  end

  // ALU operand/op registers change only on acceptance
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_rsp_illegal <= 1'b0;
    end else if (w_accept) begin
      r_alu_a       <= req_a;
      r_alu_b       <= req_b;
      r_alu_op      <= req_op;
      r_rsp_illegal <= (req_op > 5'd3);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_rsp_data <= '0;
    end else if (w_capture) begin
      r_rsp_data <= alu_c;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_done_count <= '0;
    end else if (w_rsp_hs) begin
      r_done_count <= r_done_count + CNT_W'(1);
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign rsp_data    = r_rsp_data;
  assign rsp_illegal = r_rsp_illegal;
  assign done_count  = r_done_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench: two controller instances (SETTLE_CYC=1/CNT_W=2 and
// SETTLE_CYC=3/CNT_W=16) driven against a transaction-level model of the ALU issue flow.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        clr;
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic [4:0]  req_op      [2];
  logic [31:0] req_a       [2];
  logic [31:0] req_b       [2];
  logic [31:0] alu_a       [2];
  logic [31:0] alu_b       [2];
  logic [4:0]  alu_op      [2];
  logic [31:0] alu_c       [2];
  logic        rsp_valid   [2];
  logic        rsp_ready   [2];
  logic [31:0] rsp_data    [2];
  logic        rsp_illegal [2];
  logic        busy        [2];
  logic [1:0]  dc0;
  logic [15:0] dc1;

  int          n_checks;
  int          n_fail;
  int unsigned model_cnt [2];
  int          settle    [2];

  // Combinational ALU: 0=OR, 1=AND, 2=ADD, 3=NEGATE(A), anything else AND
  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      5'd0:    return a | b;
      5'd1:    return a & b;
      5'd2:    return a + b;
      5'd3:    return 32'd0 - a;
      default: return a & b;
    endcase
  endfunction

  assign alu_c[0] = alu_fn(alu_op[0], alu_a[0], alu_b[0]);
  assign alu_c[1] = alu_fn(alu_op[1], alu_a[1], alu_b[1]);

  alu_issue_ctrl #(.SETTLE_CYC(1), .CNT_W(2)) u_dut0 (
    .clk(clk), .clr(clr),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_a(req_a[0]), .req_b(req_b[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_c(alu_c[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_illegal(rsp_illegal[0]), .busy(busy[0]), .done_count(dc0)
  );

  alu_issue_ctrl #(.SETTLE_CYC(3), .CNT_W(16)) u_dut1 (
    .clk(clk), .clr(clr),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_a(req_a[1]), .req_b(req_b[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_c(alu_c[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_illegal(rsp_illegal[1]), .busy(busy[1]), .done_count(dc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] get_dc(input int k);
    return (k == 0) ? {14'd0, dc0} : dc1;
  endfunction

  function automatic logic [15:0] exp_dc(input int k);
    return (k == 0) ? 16'(model_cnt[0] % 4) : 16'(model_cnt[1] % 65536);
  endfunction

  // One full transaction with `hold` cycles of response backpressure
  task automatic do_op(input int k, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          n;
    exp = alu_fn(op, a, b);
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_op[k]    = op;
    req_a[k]     = a;
    req_b[k]     = b;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready[k], 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    check("busy_after_accept", busy[k], 1'b1);
    check("req_ready_after_accept", req_ready[k], 1'b0);
    check("alu_a_issue", alu_a[k], a);
    check("alu_b_issue", alu_b[k], b);
    check("alu_op_issue", alu_op[k], op);
    n = 0;
    while (!rsp_valid[k] && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", n, settle[k]);
    check("rsp_data", rsp_data[k], exp);
    check("rsp_illegal", rsp_illegal[k], op > 5'd3);
    for (int i = 0; i < hold; i++) begin
      req_valid[k] = 1'b1;
      req_a[k]     = ~a;
      req_b[k]     = ~b;
      req_op[k]    = op ^ 5'd1;
      @(posedge clk);
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid[k], 1'b1);
      check("bp_rsp_data", rsp_data[k], exp);
      check("bp_req_ready", req_ready[k], 1'b0);
      check("bp_alu_a", alu_a[k], a);
      check("bp_alu_op", alu_op[k], op);
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    model_cnt[k]++;
    check("done_count", get_dc(k), exp_dc(k));
    check("rsp_valid_after_hs", rsp_valid[k], 1'b0);
    check("req_ready_after_hs", req_ready[k], 1'b1);
    check("rsp_data_kept", rsp_data[k], exp);
    check("alu_a_kept_idle", alu_a[k], a);
  endtask

  initial begin
    int          n;
    logic [4:0]  op;
    n_checks     = 0;
    n_fail       = 0;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    settle[0]    = 1;
    settle[1]    = 3;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b0;
      req_op[k]    = '0;
      req_a[k]     = '0;
      req_b[k]     = '0;
    end
    clr = 1'b0;
    #12;
    for (int k = 0; k < 2; k++) begin
      check("rst_req_ready", req_ready[k], 1'b1);
      check("rst_rsp_valid", rsp_valid[k], 1'b0);
      check("rst_busy", busy[k], 1'b0);
      check("rst_alu_a", alu_a[k], 32'd0);
      check("rst_rsp_data", rsp_data[k], 32'd0);
      check("rst_done_count", get_dc(k), 16'd0);
    end
    @(negedge clk);
    clr = 1'b1;

    do_op(0, 5'd2, 32'h0000_0005, 32'h0000_0007, 0);
    do_op(0, 5'd0, 32'hF0F0_0000, 32'h0000_0F0F, 5);
    do_op(0, 5'd7, 32'hFFFF_0000, 32'h00FF_00FF, 1);
    do_op(0, 5'd1, 32'h1234_5678, 32'h0F0F_0F0F, 0);
    do_op(1, 5'd3, 32'h0000_0001, 32'h0000_0000, 0);

    // Abort an operation during SETTLE with an asynchronous reset
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_op[1]    = 5'd2;
    req_a[1]     = 32'h0000_0011;
    req_b[1]     = 32'h0000_0022;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("abort_busy_pre", busy[1], 1'b1);
    #2;
    clr = 1'b0;
    #1;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    check("abort_busy", busy[1], 1'b0);
    check("abort_rsp_valid", rsp_valid[1], 1'b0);
    check("abort_alu_a", alu_a[1], 32'd0);
    check("abort_alu_op", alu_op[1], 5'd0);
    check("abort_rsp_data", rsp_data[1], 32'd0);
    check("abort_done_count", get_dc(1), 16'd0);
    check("abort_dc0", get_dc(0), 16'd0);
    @(negedge clk);
    clr = 1'b1;
    check("abort_req_ready", req_ready[1], 1'b1);
    repeat (4) @(negedge clk);
    check("abort_no_rsp", rsp_valid[1], 1'b0);
    check("abort_dc_hold", get_dc(1), 16'd0);

    // Counter wrap on the 2-bit instance: 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      do_op(0, 5'($urandom_range(0, 3)), $urandom, $urandom, 0);
    end

    for (int i = 0; i < 40; i++) begin
      n  = $urandom_range(0, 9);
      op = (n == 0) ? 5'($urandom_range(4, 31)) : 5'($urandom_range(0, 3));
      do_op(i % 2, op, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
